armleocpu_avl_mem_responder: RTL

//   Avalon-MM responder (slave) backed by on-chip word RAM; the target end of the bus driven by
//   the PTW and other initiators. Serves 32-bit single-beat reads/writes with configurable read

---
 rtl/armleocpu_avl_mem_responder_if.sv | 22 ++
 rtl/armleocpu_avl_mem_responder.sv | 118 +++++++++++
 2 files changed

// File: rtl/armleocpu_avl_mem_responder_if.sv
// Avalon-MM single-beat bus between an initiator (master) and the RAM-backed responder (slave).
interface armleocpu_avl_mem_responder_if;
    logic [33:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;
    logic [1:0]  avl_response;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        input  avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        output avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
    );
endinterface

// File: rtl/armleocpu_avl_mem_responder.sv
// Avalon-MM responder backed by a word RAM: one outstanding read with fixed latency,
// byte-lane writes, alignment/range error responses.
module armleocpu_avl_mem_responder #(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          async_rst_n,
    armleocpu_avl_mem_responder_if.slave  avl
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [3:0] CNT_INIT    = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_WAIT,
        STATE_RESP
    } state_t;

    logic [31:0] mem [2**DEPTH_LOG2];

    state_t                  state_q, state_d;
    logic [3:0]              counter_q, counter_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [1:0]              resp_q, resp_d;

    logic [1:0]              decode_resp;
    logic [DEPTH_LOG2-1:0]   cmd_idx;
    logic                    busy;
    logic                    read_accept;
    logic                    mem_we;

    assign cmd_idx     = avl.avl_address[DEPTH_LOG2+1:2];
    assign busy        = (state_q == STATE_WAIT);
    assign read_accept = avl.avl_read && !busy;
    // A combined read+write is handled as an erroring read, so it never touches RAM.
    assign mem_we      = avl.avl_write && !avl.avl_read && !busy && (decode_resp == RESP_OKAY);

    // Misalignment takes priority over an out-of-range address.
    always_comb begin
        decode_resp = RESP_OKAY;
        if (avl.avl_address[1:0] != 2'b00) begin
            decode_resp = RESP_SLVERR;
        end else if ((avl.avl_address >> (DEPTH_LOG2 + 2)) != 34'd0) begin
            decode_resp = RESP_DECERR;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q   <= STATE_IDLE;
            counter_q <= 4'd0;
            idx_q     <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            idx_q     <= idx_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        idx_d     = idx_q;
        resp_d    = resp_q;
        case (state_q)
            STATE_IDLE, STATE_RESP: begin
                if (read_accept) begin
                    idx_d     = cmd_idx;
                    resp_d    = avl.avl_write ? RESP_SLVERR : decode_resp;
                    counter_d = CNT_INIT;
                    state_d   = (READ_LATENCY == 1) ? STATE_RESP : STATE_WAIT;
                end else begin
                    state_d   = STATE_IDLE;
                end
            end
            STATE_WAIT: begin
                counter_d = counter_q - 4'd1;
                if (counter_q <= 4'd1) begin
                    state_d = STATE_RESP;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // Read data comes straight from RAM in the response cycle; error reads return zero.
    always_comb begin
        avl.avl_waitrequest   = (state_q == STATE_WAIT);
        avl.avl_readdatavalid = (state_q == STATE_RESP);
        avl.avl_response      = RESP_OKAY;
        avl.avl_readdata      = 32'd0;
        if (state_q == STATE_RESP) begin
            avl.avl_response = resp_q;
            if (resp_q == RESP_OKAY) begin
                avl.avl_readdata = mem[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (avl.avl_byteenable[i]) begin
                    mem[cmd_idx][8*i +: 8] <= avl.avl_writedata[8*i +: 8];
                end
            end
        end
    end

endmodule
